// File: rtl/coredma_bd_pkg.sv
// Shared types and constants for the DMA buffer-descriptor SRAM reader.
package coredma_bd_pkg;

   localparam int ADDR_W       = 9;
   localparam int DATA_W       = 32;
   localparam int WORDS_PER_BD = 4;
   localparam int IDX_W        = ADDR_W - 2;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      PRESENT
   } bd_rd_state_t;

   // Word offsets inside a descriptor, used by downstream decode
   localparam int WORD_CTRL = 0;
   localparam int WORD_SRC  = 1;
   localparam int WORD_DST  = 2;
   localparam int WORD_LEN  = 3;

endpackage

// File: rtl/coredma_bd_rdlat_pipe.sv
// Tracks issued SRAM reads until their data returns, RD_LAT cycles later.
module coredma_bd_rdlat_pipe #(
   parameter int DEPTH = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       in_valid,
   input  logic       in_retry,
   input  logic [1:0] in_word,
   output logic       out_valid,
   output logic       out_retry,
   output logic [1:0] out_word,
   output logic       pending
);

   logic [DEPTH-1:0]      vld_q;
   logic [DEPTH-1:0]      rty_q;
   logic [DEPTH-1:0][1:0] wrd_q;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         vld_q <= '0;
         rty_q <= '0;
         wrd_q <= '0;
      end else begin
         vld_q[0] <= in_valid;
         rty_q[0] <= in_retry;
         wrd_q[0] <= in_word;
         for (int i = 1; i < DEPTH; i++) begin
            vld_q[i] <= vld_q[i-1];
            rty_q[i] <= rty_q[i-1];
            wrd_q[i] <= wrd_q[i-1];
         end
      end
   end

   assign out_valid = vld_q[DEPTH-1];
   assign out_retry = rty_q[DEPTH-1];
   assign out_word  = wrd_q[DEPTH-1];

   // Entries still in flight after the one retiring this cycle
   always_comb begin
      pending = 1'b0;
      for (int i = 0; i < DEPTH - 1; i++) begin
         pending = pending | vld_q[i];
      end
   end

endmodule

// File: rtl/coredma_bd_sram_reader.sv
// Fetches one four-word descriptor from the BD SRAM and presents it
// as a single bundle over a valid/ready handshake.
module coredma_bd_sram_reader #(
   parameter int ADDR_W       = coredma_bd_pkg::ADDR_W,
   parameter int DATA_W       = coredma_bd_pkg::DATA_W,
   parameter int WORDS_PER_BD = coredma_bd_pkg::WORDS_PER_BD,
   parameter int RD_LAT       = 1
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           FLUSH,
   input  logic                           REQ_VALID,
   output logic                           REQ_READY,
   input  logic [ADDR_W-3:0]              REQ_IDX,
   output logic [ADDR_W-1:0]              R_ADDR,
   output logic                           R_EN,
   output logic                           R_DATA_EN,
   input  logic [DATA_W-1:0]              R_DATA,
   input  logic                           W_EN,
   input  logic [ADDR_W-1:0]              W_ADDR,
   output logic                           BD_VALID,
   input  logic                           BD_READY,
   output logic [ADDR_W-3:0]              BD_IDX,
   output logic [WORDS_PER_BD*DATA_W-1:0] BD_DATA
);

   import coredma_bd_pkg::*;

   localparam int IDX_W = ADDR_W - 2;

   bd_rd_state_t state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [1:0]       w_q, w_d;

   logic [WORDS_PER_BD-1:0][DATA_W-1:0] words_q;

   logic       collide;
   logic       pending;
   logic       out_valid;
   logic       out_retry;
   logic [1:0] out_word;

   assign R_ADDR  = {idx_q, w_q};
   assign BD_IDX  = idx_q;
   assign BD_DATA = words_q;

   // A write landing on the word being read returns undefined data
   assign collide = W_EN && (W_ADDR == R_ADDR);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      w_d       = w_q;
      REQ_READY = 1'b0;
      R_EN      = 1'b0;
      BD_VALID  = 1'b0;
      unique case (state_q)
         IDLE: begin
            REQ_READY = !FLUSH;
            if (REQ_VALID && !FLUSH) begin
               idx_d   = REQ_IDX;
               w_d     = 2'd0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            R_EN = 1'b1;
            if (!collide) begin
               w_d = w_q + 2'd1;
               if (w_q == 2'd3) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (!pending) begin
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            BD_VALID = !FLUSH;
            if (BD_READY && !FLUSH) begin
               state_d = IDLE;
            end
         end
      endcase
      if (FLUSH) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         idx_q   <= '0;
         w_q     <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         w_q     <= w_d;
      end
   end

   coredma_bd_rdlat_pipe #(
      .DEPTH (RD_LAT)
   ) u_pipe (
      .clk       (CLK),
      .rst       (RST),
      .flush     (FLUSH),
      .in_valid  (R_EN),
      .in_retry  (collide),
      .in_word   (w_q),
      .out_valid (out_valid),
      .out_retry (out_retry),
      .out_word  (out_word),
      .pending   (pending)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         words_q <= '0;
      end else if (!FLUSH && out_valid && !out_retry) begin
         words_q[out_word] <= R_DATA;
      end
   end

   if (RD_LAT == 2) begin : g_oreg
      logic ren_q;
      always_ff @(posedge CLK) begin
         if (RST) begin
            ren_q <= 1'b0;
         end else begin
            ren_q <= R_EN;
         end
      end
      assign R_DATA_EN = ren_q;
   end else begin : g_noreg
      assign R_DATA_EN = 1'b1;
   end

endmodule

// File: tb/tb_coredma_bd_sram_reader.sv
// Directed bench for coredma_bd_sram_reader, RD_LAT=1 and RD_LAT=2 side by side.
module tb_coredma_bd_sram_reader;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        RST, FLUSH, REQ_VALID, BD_READY, W_EN;
   logic [6:0]  REQ_IDX;
   logic [8:0]  W_ADDR;
   logic [31:0] W_DATA;

   logic         req_ready1, r_en1, r_den1, bd_valid1;
   logic [8:0]   r_addr1;
   logic [31:0]  r_data1;
   logic [6:0]   bd_idx1;
   logic [127:0] bd_data1;

   logic         req_ready2, r_en2, r_den2, bd_valid2;
   logic [8:0]   r_addr2;
   logic [31:0]  r_data2;
   logic [6:0]   bd_idx2;
   logic [127:0] bd_data2;

   coredma_bd_sram_reader #(.RD_LAT(1)) dut1 (
      .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
      .REQ_VALID(REQ_VALID), .REQ_READY(req_ready1), .REQ_IDX(REQ_IDX),
      .R_ADDR(r_addr1), .R_EN(r_en1), .R_DATA_EN(r_den1), .R_DATA(r_data1),
      .W_EN(W_EN), .W_ADDR(W_ADDR),
      .BD_VALID(bd_valid1), .BD_READY(BD_READY),
      .BD_IDX(bd_idx1), .BD_DATA(bd_data1)
   );

   coredma_bd_sram_reader #(.RD_LAT(2)) dut2 (
      .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
      .REQ_VALID(REQ_VALID), .REQ_READY(req_ready2), .REQ_IDX(REQ_IDX),
      .R_ADDR(r_addr2), .R_EN(r_en2), .R_DATA_EN(r_den2), .R_DATA(r_data2),
      .W_EN(W_EN), .W_ADDR(W_ADDR),
      .BD_VALID(bd_valid2), .BD_READY(BD_READY),
      .BD_IDX(bd_idx2), .BD_DATA(bd_data2)
   );

   function automatic logic [31:0] iw(input int a);
      if (a >= 40 && a <= 43) return 32'(32'hA0 + a - 40);
      return 32'hC000_0000 | 32'(a);
   endfunction

   // SRAM model; a same-cycle write/read collision returns poison
   logic [31:0] mem [512];
   logic [31:0] rd1, rd2a, rd2b;
   localparam logic [31:0] POISON = 32'hDEAD_BEEF;

   always @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < 512; i++) mem[i] <= iw(i);
      end else if (W_EN) begin
         mem[W_ADDR] <= W_DATA;
      end
      if (r_en1) rd1 <= (W_EN && W_ADDR == r_addr1) ? POISON : mem[r_addr1];
      if (r_en2) rd2a <= (W_EN && W_ADDR == r_addr2) ? POISON : mem[r_addr2];
      if (r_den2) rd2b <= rd2a;
   end

   assign r_data1 = rd1;
   assign r_data2 = rd2b;

   int checks = 0;
   int failures = 0;

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b", nm, act, exp);
      end
   endtask

   task automatic chkw(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic wait_both(input int budget, input string nm);
      int n = 0;
      while (!(bd_valid1 && bd_valid2) && n < budget) begin
         @(negedge CLK); #1;
         n++;
      end
      chk1({nm, "_wait_valid"}, bd_valid1 && bd_valid2, 1'b1);
   endtask

   typedef struct {
      logic         rv;
      logic [6:0]   ridx;
      logic         brdy;
      logic         wen;
      logic [8:0]   waddr;
      logic [31:0]  wdata;
      logic         rdy;
      logic         ren;
      logic [8:0]   raddr;
      logic         rden2;
      logic         bv1;
      logic         bv2;
      logic         chk;
      logic [127:0] bd;
      logic [6:0]   bidx;
   } vec_t;

   function automatic vec_t mk(input int rv, ridx, brdy, wen, waddr,
                               input logic [31:0] wdata,
                               input int rdy, ren, raddr, rden2, bv1, bv2,
                               input int chk,
                               input logic [127:0] bd,
                               input int bidx);
      vec_t v;
      v.rv = 1'(rv);      v.ridx = 7'(ridx);   v.brdy = 1'(brdy);
      v.wen = 1'(wen);    v.waddr = 9'(waddr); v.wdata = wdata;
      v.rdy = 1'(rdy);    v.ren = 1'(ren);     v.raddr = 9'(raddr);
      v.rden2 = 1'(rden2);
      v.bv1 = 1'(bv1);    v.bv2 = 1'(bv2);
      v.chk = 1'(chk);    v.bd = bd;           v.bidx = 7'(bidx);
      return v;
   endfunction

   localparam logic [127:0] BD_A = 128'h000000A3_000000A2_000000A1_000000A0;
   localparam logic [127:0] BD_C = 128'h000000A3_000000A2_00000055_000000A0;

   vec_t tbl[$];
   logic [127:0] bd_bp, bd_wrap;
   logic seen;

   initial begin
      RST = 1'b1; FLUSH = 1'b0; REQ_VALID = 1'b0; REQ_IDX = '0;
      BD_READY = 1'b0; W_EN = 1'b0; W_ADDR = '0; W_DATA = '0;
      bd_bp   = {iw(23), iw(22), iw(21), iw(20)};
      bd_wrap = {iw(511), iw(510), iw(509), iw(508)};

      // plain fetch of idx 10
      tbl.push_back(mk(1,10,0, 0,0,0, 1,0,0,0, 0,0, 0,0,0));
      tbl.push_back(mk(0,0,0,  0,0,0, 0,1,40,0, 0,0, 0,0,0));
      tbl.push_back(mk(0,0,0,  0,0,0, 0,1,41,1, 0,0, 0,0,0));
      tbl.push_back(mk(0,0,0,  0,0,0, 0,1,42,1, 0,0, 0,0,0));
      tbl.push_back(mk(0,0,0,  0,0,0, 0,1,43,1, 0,0, 0,0,0));
      tbl.push_back(mk(0,0,0,  0,0,0, 0,0,0,1,  0,0, 0,0,0));
      tbl.push_back(mk(0,0,0,  0,0,0, 0,0,0,0,  1,0, 0,0,0));
      tbl.push_back(mk(0,0,1,  0,0,0, 0,0,0,0,  1,1, 0,0,0));
      tbl.push_back(mk(0,0,0,  0,0,0, 1,0,0,0,  0,0, 1,BD_A,10));
      // same fetch with a write colliding on word 1
      tbl.push_back(mk(1,10,0, 0,0,0,     1,0,0,0,  0,0, 0,0,0));
      tbl.push_back(mk(0,0,0,  0,0,0,     0,1,40,0, 0,0, 0,0,0));
      tbl.push_back(mk(0,0,0,  1,41,'h55, 0,1,41,1, 0,0, 0,0,0));
      tbl.push_back(mk(0,0,0,  0,0,0,     0,1,41,1, 0,0, 0,0,0));
      tbl.push_back(mk(0,0,0,  0,0,0,     0,1,42,1, 0,0, 0,0,0));
      tbl.push_back(mk(0,0,0,  0,0,0,     0,1,43,1, 0,0, 0,0,0));
      tbl.push_back(mk(0,0,0,  0,0,0,     0,0,0,1,  0,0, 0,0,0));
      tbl.push_back(mk(0,0,0,  0,0,0,     0,0,0,0,  1,0, 0,0,0));
      tbl.push_back(mk(0,0,1,  0,0,0,     0,0,0,0,  1,1, 0,0,0));
      tbl.push_back(mk(0,0,0,  0,0,0,     1,0,0,0,  0,0, 1,BD_C,10));

      repeat (2) @(posedge CLK);
      @(negedge CLK); RST = 1'b0; #1;
      chk1("rst_req_ready1", req_ready1, 1'b1);
      chk1("rst_req_ready2", req_ready2, 1'b1);
      chk1("rst_bd_valid1", bd_valid1, 1'b0);
      chk1("rst_bd_valid2", bd_valid2, 1'b0);
      chk1("rst_r_en1", r_en1, 1'b0);
      chk1("rst_r_en2", r_en2, 1'b0);
      chkw("rst_r_addr1", 128'(r_addr1), 128'(0));
      chkw("rst_bd_data1", bd_data1, 128'(0));
      chkw("rst_bd_data2", bd_data2, 128'(0));
      chkw("rst_bd_idx1", 128'(bd_idx1), 128'(0));
      chk1("rst_r_den2", r_den2, 1'b0);

      foreach (tbl[i]) begin
         @(negedge CLK);
         REQ_VALID = tbl[i].rv;  REQ_IDX = tbl[i].ridx;
         BD_READY = tbl[i].brdy; W_EN = tbl[i].wen;
         W_ADDR = tbl[i].waddr;  W_DATA = tbl[i].wdata;
         #1;
         chk1($sformatf("v%0d_req_ready1", i), req_ready1, tbl[i].rdy);
         chk1($sformatf("v%0d_req_ready2", i), req_ready2, tbl[i].rdy);
         chk1($sformatf("v%0d_r_en1", i), r_en1, tbl[i].ren);
         chk1($sformatf("v%0d_r_en2", i), r_en2, tbl[i].ren);
         if (tbl[i].ren) begin
            chkw($sformatf("v%0d_r_addr1", i), 128'(r_addr1), 128'(tbl[i].raddr));
            chkw($sformatf("v%0d_r_addr2", i), 128'(r_addr2), 128'(tbl[i].raddr));
         end
         chk1($sformatf("v%0d_r_den1", i), r_den1, 1'b1);
         chk1($sformatf("v%0d_r_den2", i), r_den2, tbl[i].rden2);
         chk1($sformatf("v%0d_bd_valid1", i), bd_valid1, tbl[i].bv1);
         chk1($sformatf("v%0d_bd_valid2", i), bd_valid2, tbl[i].bv2);
         if (tbl[i].chk) begin
            chkw($sformatf("v%0d_bd_data1", i), bd_data1, tbl[i].bd);
            chkw($sformatf("v%0d_bd_data2", i), bd_data2, tbl[i].bd);
            chkw($sformatf("v%0d_bd_idx1", i), 128'(bd_idx1), 128'(tbl[i].bidx));
            chkw($sformatf("v%0d_bd_idx2", i), 128'(bd_idx2), 128'(tbl[i].bidx));
         end
      end

      // backpressure: hold BD_READY low for 10 cycles
      @(negedge CLK); REQ_VALID = 1'b1; REQ_IDX = 7'd5; BD_READY = 1'b0; #1;
      @(negedge CLK); REQ_VALID = 1'b0; #1;
      wait_both(20, "bp");
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK); #1;
         chk1($sformatf("bp%0d_valid1", k), bd_valid1, 1'b1);
         chk1($sformatf("bp%0d_valid2", k), bd_valid2, 1'b1);
         chkw($sformatf("bp%0d_data1", k), bd_data1, bd_bp);
         chkw($sformatf("bp%0d_data2", k), bd_data2, bd_bp);
         chk1($sformatf("bp%0d_req_ready1", k), req_ready1, 1'b0);
         chk1($sformatf("bp%0d_req_ready2", k), req_ready2, 1'b0);
      end
      @(negedge CLK); BD_READY = 1'b1; #1;
      @(negedge CLK); BD_READY = 1'b0; #1;
      chk1("bp_done_req_ready1", req_ready1, 1'b1);
      chk1("bp_done_req_ready2", req_ready2, 1'b1);
      chk1("bp_done_valid1", bd_valid1, 1'b0);
      chk1("bp_done_valid2", bd_valid2, 1'b0);
      chkw("bp_done_idx1", 128'(bd_idx1), 128'(5));

      // flush during the word-2 issue, then fetch the last descriptor
      @(negedge CLK); REQ_VALID = 1'b1; REQ_IDX = 7'd20; #1;
      @(negedge CLK); REQ_VALID = 1'b0; #1;
      chkw("fl_addr_w0", 128'(r_addr1), 128'(80));
      @(negedge CLK); #1;
      @(negedge CLK); FLUSH = 1'b1; #1;
      chkw("fl_addr_w2", 128'(r_addr1), 128'(82));
      chk1("fl_r_en_w2", r_en1, 1'b1);
      @(negedge CLK); FLUSH = 1'b0; #1;
      chk1("fl_req_ready1", req_ready1, 1'b1);
      chk1("fl_req_ready2", req_ready2, 1'b1);
      chk1("fl_r_en1", r_en1, 1'b0);
      chk1("fl_r_en2", r_en2, 1'b0);
      seen = 1'b0;
      repeat (8) begin
         @(negedge CLK); #1;
         seen = seen | bd_valid1 | bd_valid2;
      end
      chk1("fl_no_valid", seen, 1'b0);
      @(negedge CLK); REQ_VALID = 1'b1; REQ_IDX = 7'd127; #1;
      @(negedge CLK); REQ_VALID = 1'b0; #1;
      chkw("wrap_addr_w0", 128'(r_addr1), 128'(508));
      wait_both(20, "wrap");
      chkw("wrap_data1", bd_data1, bd_wrap);
      chkw("wrap_data2", bd_data2, bd_wrap);
      chkw("wrap_idx1", 128'(bd_idx1), 128'(127));
      chkw("wrap_idx2", 128'(bd_idx2), 128'(127));

      // reset while presenting
      @(negedge CLK); RST = 1'b1; #1;
      @(negedge CLK); RST = 1'b0; #1;
      chk1("rp_valid1", bd_valid1, 1'b0);
      chk1("rp_valid2", bd_valid2, 1'b0);
      chk1("rp_req_ready1", req_ready1, 1'b1);
      chk1("rp_req_ready2", req_ready2, 1'b1);
      chkw("rp_data1", bd_data1, 128'(0));
      chkw("rp_data2", bd_data2, 128'(0));
      chk1("rp_r_en1", r_en1, 1'b0);
      chk1("rp_r_en2", r_en2, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/coredma_bd_sram_reader.md
Name: coredma_bd_sram_reader

Overview:
- Read-side engine for the DMA buffer-descriptor SRAM: 512 x 32 two-port, registered-output option.
- Accepts a descriptor index and issues four word reads on the SRAM read port.
- Tracks the SRAM read latency and assembles one 128-bit descriptor.
- Presents the descriptor to the DMA channel logic over a valid/ready handshake.
- Snoops the SRAM write port so a same-cycle write/read collision never returns undefined data.

Parameters:
- ADDR_W, 9: SRAM word-address width.
- DATA_W, 32: SRAM word width.
- WORDS_PER_BD, 4: words per descriptor. Fixed at 4; IDX_W = ADDR_W-2.
- RD_LAT, 1: SRAM read latency in cycles. 1 = output register bypassed; 2 = output register enabled.

Ports:
- CLK  in  1  sole clock; SRAM shares it.
- RST  in  1  synchronous, active-high reset.
- FLUSH  in  1  synchronous abort of the current fetch.
- REQ_VALID  in  1  fetch request.
- REQ_READY  out  1  engine can accept a request.
- REQ_IDX  in  IDX_W  descriptor index (0..127).
- R_ADDR  out  ADDR_W  SRAM read address.
- R_EN  out  1  SRAM read enable.
- R_DATA_EN  out  1  SRAM output-register enable. Equals the delayed R_EN when RD_LAT=2; tied 1 when RD_LAT=1.
- R_DATA  in  DATA_W  SRAM read data.
- W_EN  in  1  SRAM write-port enable (snoop only).
- W_ADDR  in  ADDR_W  SRAM write address (snoop only).
- BD_VALID  out  1  descriptor available.
- BD_READY  in  1  consumer accepts the descriptor.
- BD_IDX  out  IDX_W  index of the presented descriptor.
- BD_DATA  out  4*DATA_W  word k in bits [32k+31:32k].

Behaviour:
- Reset (RST=1 at a clock edge):
  - FSM goes to IDLE.
  - REQ_READY=1 in the first cycle after reset; BD_VALID=0, R_EN=0.
  - R_ADDR, BD_DATA and BD_IDX are all 0.
  - Pending latency pipeline entries are discarded.
- FSM states: IDLE, ISSUE, DRAIN, PRESENT.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID at cycle t: latch REQ_IDX, set word counter w=0, go to ISSUE.
- ISSUE:
  - R_EN=1, R_ADDR={idx, w[1:0]}.
  - Collision: if W_EN=1 and W_ADDR==R_ADDR in the same cycle, the word is marked retry. w does not advance; the same address is reissued next cycle.
  - Otherwise w increments.
  - After w=3 issues without collision, go to DRAIN.
- Latency pipeline:
  - A shift register of depth RD_LAT carries {valid, retry, word number}.
  - At the cycle R_DATA is valid (issue+RD_LAT), a non-retry entry writes R_DATA into word register k.
  - Retry entries are discarded.
- DRAIN:
  - Wait until the pipeline is empty, then go to PRESENT.
- PRESENT:
  - BD_VALID=1; BD_DATA and BD_IDX are held stable.
  - On BD_VALID & BD_READY, go to IDLE.
  - REQ_READY=0 during PRESENT, so there is no overlap.
  - BD_DATA is held until the next descriptor loads.
- Latency, no collisions, no backpressure:
  - Request accepted at cycle t.
  - Issues in cycles t+1..t+4.
  - BD_VALID rises in cycle t+5+RD_LAT.
  - Each collision adds exactly 1 cycle.
- FLUSH:
  - In any state, returns the FSM to IDLE next cycle with BD_VALID=0.
  - Clears the pipeline valid bits; no partially assembled descriptor is ever presented.
  - FLUSH has priority over REQ_VALID and BD_READY in the same cycle.
  - RST has priority over FLUSH.
- Address wrap: idx=127 covers words 508..511. There is no carry into other descriptors.
- Writes to a descriptor's words after their read has issued are not detected. Software owns ordering: no write to a descriptor while it is being fetched.
- R_EN=0 in all states except ISSUE. The SRAM read port idles between fetches.

Decomposition:
- Shared package coredma_bd_pkg:
  - constants ADDR_W, DATA_W, WORDS_PER_BD, IDX_W;
  - enum bd_rd_state_t {IDLE, ISSUE, DRAIN, PRESENT};
  - descriptor word offset constants (WORD_CTRL=0, WORD_SRC=1, WORD_DST=2, WORD_LEN=3) for downstream decode.
- One sub-module: coredma_bd_rdlat_pipe, a parameterised RD_LAT-deep {valid, retry, word} shift register with flush.
- The FSM and word registers live in the top.

Test Plan:
1. Preload SRAM words 40..43 = 0xA0..0xA3. With RD_LAT=1, request idx=10 at cycle 0 → R_ADDR 40,41,42,43 in cycles 1..4; BD_VALID in cycle 6; BD_DATA=0x000000A3_000000A2_000000A1_000000A0; BD_IDX=10.
2. Same as scenario 1 with RD_LAT=2 → BD_VALID in cycle 7; R_DATA_EN mirrors R_EN delayed by 1; same BD_DATA.
3. Collision: W_EN=1, W_ADDR=41, W_DATA=0x55 in the cycle R_ADDR=41 → 41 reissued next cycle; BD_VALID one cycle later than scenario 1; word1=0x55.
4. BD_READY held 0 for 10 cycles → BD_VALID and BD_DATA stable throughout, REQ_READY=0; on BD_READY=1, IDLE and REQ_READY=1 next cycle.
5. FLUSH asserted in the cycle word 2 is issued → IDLE next cycle; BD_VALID never rises; a new request idx=127 then returns words 508..511 correctly.
6. RST asserted while in PRESENT → next cycle BD_VALID=0, REQ_READY=1, BD_DATA=0, R_EN=0.
